// File: rtl/mcpu_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM data port.
// Each access runs IDLE (grant) -> ACCESS (RAM strobe) -> DONE (ack).
module mcpu_ram_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_SIZE-1:0]  wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_SIZE-1:0]  wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [WORD_SIZE-1:0]  rdata0,
  output logic [WORD_SIZE-1:0]  rdata1,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_datawr,
  input  logic [WORD_SIZE-1:0]  ram_datard,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            state_s;
  logic                  owner_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WORD_SIZE-1:0]  wdata_r;
  logic                  last_r;
  logic [WORD_SIZE-1:0]  rdata0_r;
  logic [WORD_SIZE-1:0]  rdata1_r;
  logic                  ram_we_r;
  logic                  ram_re_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  busy_r;

  logic                  gnt_any_s;
  logic                  sel_owner_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WORD_SIZE-1:0]  sel_wdata_s;

  // Next-state and arbitration; the grant is a same-cycle decision in IDLE.
  always_comb begin
    state_s     = state_r;
    gnt_any_s   = 1'b0;
    sel_owner_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          // last_r names the previous owner; the other one wins the tie.
          gnt_any_s   = 1'b1;
          sel_owner_s = ~last_r;
          state_s     = ST_ACCESS;
        end else if (req0) begin
          gnt_any_s   = 1'b1;
          sel_owner_s = 1'b0;
          state_s     = ST_ACCESS;
        end else if (req1) begin
          gnt_any_s   = 1'b1;
          sel_owner_s = 1'b1;
          state_s     = ST_ACCESS;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_ACCESS: state_s = ST_DONE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Mux the winning requester's access attributes.
  always_comb begin
    if (sel_owner_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // State, latched access, pre-decoded strobes and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      owner_r  <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r  <= {WORD_SIZE{1'b0}};
      last_r   <= 1'b1;
      rdata0_r <= {WORD_SIZE{1'b0}};
      rdata1_r <= {WORD_SIZE{1'b0}};
      ram_we_r <= 1'b0;
      ram_re_r <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (gnt_any_s) begin
        owner_r <= sel_owner_s;
        we_r    <= sel_we_s;
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
      end
      // Strobes are decoded one cycle early so they come straight from flops.
      ram_we_r <= gnt_any_s & sel_we_s;
      ram_re_r <= gnt_any_s & ~sel_we_s;
      ack0_r   <= (state_r == ST_ACCESS) & ~owner_r;
      ack1_r   <= (state_r == ST_ACCESS) & owner_r;
      busy_r   <= (state_s != ST_IDLE);
      if ((state_r == ST_ACCESS) && !we_r) begin
        if (owner_r) begin
          rdata1_r <= ram_datard;
        end else begin
          rdata0_r <= ram_datard;
        end
      end
      if (state_r == ST_DONE) begin
        last_r <= owner_r;
      end
    end
  end

  assign gnt0       = gnt_any_s & ~sel_owner_s;
  assign gnt1       = gnt_any_s & sel_owner_s;
  assign ack0       = ack0_r;
  assign ack1       = ack1_r;
  assign rdata0     = rdata0_r;
  assign rdata1     = rdata1_r;
  assign ram_we     = ram_we_r;
  assign ram_re     = ram_re_r;
  assign ram_addr   = addr_r;
  assign ram_datawr = wdata_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Directed self-checking bench for mcpu_ram_arbiter with a behavioural RAM
// whose read data is combinational from ram_addr.
module tb_mcpu_ram_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we, ram_re;
  logic [7:0] ram_addr, ram_datawr, ram_datard;
  logic       busy;

  logic [7:0] mem [256];
  int         errors;
  int         checks;

  mcpu_ram_arbiter #(.WORD_SIZE(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_datawr(ram_datawr), .ram_datard(ram_datard), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_datard = mem[ram_addr];

  // Behavioural RAM write port.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_datawr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full access by requester n; entered and left at posedge+1 in IDLE.
  task automatic access(input int n, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    if (n == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    #1;
    check("gnt0", gnt0, n == 0);
    check("gnt1", gnt1, n == 1);
    check("busy_idle", busy, 1'b0);
    @(posedge clk); #1;
    // Requester inputs are scrambled after the grant; latched values must win.
    req0 = 1'b0; req1 = 1'b0; addr0 = 8'h77; addr1 = 8'h77;
    wdata0 = 8'hEE; wdata1 = 8'hEE;
    #1;
    check("ram_we", ram_we, we);
    check("ram_re", ram_re, !we);
    check("dual_strobe", ram_we & ram_re, 1'b0);
    check("ram_addr", ram_addr, a);
    if (we) check("ram_datawr", ram_datawr, d);
    check("gnt_access", gnt0 | gnt1, 1'b0);
    check("busy_access", busy, 1'b1);
    @(posedge clk); #2;
    check("ack0", ack0, n == 0);
    check("ack1", ack1, n == 1);
    check("strobe_done", ram_we | ram_re, 1'b0);
    if (!we) begin
      if (n == 0) check("rdata0", rdata0, exp_rd);
      else        check("rdata1", rdata1, exp_rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0; checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 8'h1A : 8'h29;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {ram_we, ram_re, ack0, ack1}, 4'b0000);
    check("rst_rdata0", rdata0, 8'h00);
    check("rst_rdata1", rdata1, 8'h00);
    check("rst_addr", ram_addr, 8'h00);
    check("rst_datawr", ram_datawr, 8'h00);
    reset = 1'b0;

    access(0, 1'b1, 8'h05, 8'h1A, 8'h00);
    check("mem05", mem[5], 8'h1A);
    access(1, 1'b0, 8'hFF, 8'h00, 8'h29);
    access(0, 1'b0, 8'h00, 8'h00, 8'h1A);
    check("rdata1_held", rdata1, 8'h29);
    access(0, 1'b1, 8'h10, 8'h55, 8'h00);
    check("mem10", mem[16], 8'h55);

    // Contention right after reset: grants alternate 0,1,0,1 every 3 cycles.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h60;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h31; wdata1 = 8'h61;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("cont_gnt0", gnt0, (k % 3 == 0) && ((k / 3) % 2 == 0));
      check("cont_gnt1", gnt1, (k % 3 == 0) && ((k / 3) % 2 == 1));
      check("cont_ack0", ack0, (k % 3 == 2) && ((k / 3) % 2 == 0));
      check("cont_ack1", ack1, (k % 3 == 2) && ((k / 3) % 2 == 1));
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_mem30", mem[8'h30], 8'h60);
    check("cont_mem31", mem[8'h31], 8'h61);

    // Leave last=0, then abandon a read by requester 1 with reset in ACCESS.
    access(0, 1'b0, 8'h30, 8'h00, 8'h60);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
    #1;
    check("mid_gnt1", gnt1, 1'b1);
    @(posedge clk); #1;
    req1 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_ack", {ack0, ack1}, 2'b00);
    check("mid_rdata1", rdata1, 8'h00);
    @(posedge clk); #2;
    check("mid_noack", {ack0, ack1}, 2'b00);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 8'h31; addr1 = 8'h30;
    #1;
    check("mid_tie_gnt0", gnt0, 1'b1);
    check("mid_tie_gnt1", gnt1, 1'b0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #2;
    check("mid_ack0", ack0, 1'b1);
    check("mid_rdata0", rdata0, 8'h61);
    @(posedge clk); #1;

    // Full address sweep, alternating requesters.
    for (int i = 0; i < 256; i++) access(i % 2, 1'b1, 8'(i), 8'(i) ^ 8'hA5, 8'h00);
    for (int i = 0; i < 256; i++) access((i + 1) % 2, 1'b0, 8'(i), 8'h00, 8'(i) ^ 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
